aib_tx_framer: RTL and testbench

AIB_TX_FRAMER -- requirements
Module: aib_tx_framer

---
 rtl/aib_tx_framer.sv | 145 ++++++++++++++
 tb/tb_aib_tx_framer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aib_tx_framer.sv
// AIB core-side TX framer: buffers 64-bit payloads, stamps type/seq/parity into
// 72-bit flits, and inserts an idle flit after a run of empty cycles.
module aib_tx_framer #(
  parameter int DEPTH       = 4,
  parameter int IDLE_CYCLES = 64
) (
  input  logic                     i_aib_clk,
  input  logic                     i_rst,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [63:0]              i_in_data,
  input  logic [2:0]               i_in_type,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [71:0]              o_tx_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_type_err
);

  // state   | meaning
  // ST_DATA | FIFO head (if any) drives the TX port
  // ST_IDLE | idle flit is pending and held until the adapter takes it

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [7:0]    IDLE_MAX = 8'(IDLE_CYCLES);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [71:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      seq_q, seq_d;
  logic [3:0]      idle_seq_q, idle_seq_d;
  logic [7:0]      idle_cnt_q, idle_cnt_d;
  logic            type_err_q, type_err_d;

  logic            push;
  logic            pop_fifo;
  logic            pop_idle;
  logic            fifo_nonempty;
  logic [70:0]     push_body;
  logic [71:0]     push_flit;
  logic [70:0]     idle_body;
  logic [71:0]     idle_flit;

  assign fifo_nonempty = (count_q != '0);
  assign o_in_ready    = !i_rst && (count_q < DEPTH_C);
  assign push          = i_in_valid && o_in_ready;
  assign o_tx_valid    = (state_q == ST_IDLE) || fifo_nonempty;
  assign pop_idle      = (state_q == ST_IDLE) && i_tx_ready;
  assign pop_fifo      = (state_q == ST_DATA) && fifo_nonempty && i_tx_ready;

  // Parity bit makes the XOR of all 72 bits zero.
  assign push_body = {seq_q, i_in_type, i_in_data};
  assign push_flit = {^push_body, push_body};
  assign idle_body = {idle_seq_q, 3'b000, 64'd0};
  assign idle_flit = {^idle_body, idle_body};

  assign o_tx_data  = (state_q == ST_IDLE) ? idle_flit : mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_type_err = type_err_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_d      = seq_q;
    idle_seq_d = idle_seq_q;
    idle_cnt_d = idle_cnt_q;
    type_err_d = push && (i_in_type == 3'b000);

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      seq_d    = seq_q + 4'd1;
    end
    if (pop_fifo) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop_fifo})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push || pop_idle) begin
      idle_cnt_d = 8'd0;
    end else if (!fifo_nonempty && (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end

    case (state_q)
      ST_DATA: begin
        // Seq is frozen into the idle flit so later pushes cannot disturb it.
        if (!fifo_nonempty && !push && (idle_cnt_d == IDLE_MAX)) begin
          state_d    = ST_IDLE;
          idle_seq_d = seq_q;
        end
      end
      ST_IDLE: begin
        if (i_tx_ready) begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge i_aib_clk) begin
    if (i_rst) begin
      state_q    <= ST_DATA;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= 4'd0;
      idle_seq_q <= 4'd0;
      idle_cnt_q <= 8'd0;
      type_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      idle_seq_q <= idle_seq_d;
      idle_cnt_q <= idle_cnt_d;
      type_err_q <= type_err_d;
    end
  end

  always_ff @(posedge i_aib_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_flit;
    end
  end

endmodule

// File: tb/tb_aib_tx_framer.sv
// Directed bench for aib_tx_framer: one instance at default idle timeout, one
// with IDLE_CYCLES=4 for idle-flit insertion.
module tb_aib_tx_framer;

  logic        clk;
  logic        rst, in_valid, tx_ready;
  logic [63:0] in_data;
  logic [2:0]  in_type;
  logic        in_ready, tx_valid, type_err;
  logic [71:0] tx_data;
  logic [2:0]  count;

  logic        rst2, in_valid2, tx_ready2;
  logic [63:0] in_data2;
  logic [2:0]  in_type2;
  logic        in_ready2, tx_valid2, type_err2;
  logic [71:0] tx_data2;
  logic [2:0]  count2;

  int n_chk  = 0;
  int n_pass = 0;

  aib_tx_framer #(.DEPTH(4), .IDLE_CYCLES(64)) u_dut (
    .i_aib_clk (clk),
    .i_rst     (rst),
    .i_in_valid(in_valid),
    .o_in_ready(in_ready),
    .i_in_data (in_data),
    .i_in_type (in_type),
    .o_tx_valid(tx_valid),
    .i_tx_ready(tx_ready),
    .o_tx_data (tx_data),
    .o_count   (count),
    .o_type_err(type_err)
  );

  aib_tx_framer #(.DEPTH(4), .IDLE_CYCLES(4)) u_idle (
    .i_aib_clk (clk),
    .i_rst     (rst2),
    .i_in_valid(in_valid2),
    .o_in_ready(in_ready2),
    .i_in_data (in_data2),
    .i_in_type (in_type2),
    .o_tx_valid(tx_valid2),
    .i_tx_ready(tx_ready2),
    .o_tx_data (tx_data2),
    .o_count   (count2),
    .o_type_err(type_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [71:0] mk(input logic [63:0] p, input logic [2:0] t, input logic [3:0] s);
    logic [70:0] b;
    b = {s, t, p};
    return {^b, b};
  endfunction

  function automatic logic [63:0] pl(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i);
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_type = '0; tx_ready = 1'b0;
    rst2 = 1'b1; in_valid2 = 1'b0; in_data2 = '0; in_type2 = '0; tx_ready2 = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_count", 72'(count), 72'd0);
    chk("rst_tx_valid", 72'(tx_valid), 72'd0);
    chk("rst_in_ready", 72'(in_ready), 72'd0);
    chk("rst_type_err", 72'(type_err), 72'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 72'(in_ready), 72'd1);

    // single push, hand-computed flit (payload parity even, type 3 -> parity 0)
    tx_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0123_4567; in_type = 3'd3;
    tick();
    in_valid = 1'b0;
    chk("single_data", tx_data, 72'h03_DEAD_BEEF_0123_4567);
    chk("single_xor", 72'(^tx_data), 72'd0);
    chk("single_valid", 72'(tx_valid), 72'd1);
    chk("single_type_err", 72'(type_err), 72'd0);
    tick();
    chk("single_count0", 72'(count), 72'd0);
    chk("single_valid0", 72'(tx_valid), 72'd0);

    // backpressure
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = pl(i); in_type = 3'd1;
      #1;
      chk($sformatf("bp_ready_%0d", i), 72'(in_ready), 72'd1);
      tick();
    end
    in_data = pl(4);
    #1;
    chk("bp_full_ready", 72'(in_ready), 72'd0);
    chk("bp_full_count", 72'(count), 72'd4);
    chk("bp_head", tx_data, mk(pl(0), 3'd1, 4'd0));
    tick();
    chk("bp_stable_data", tx_data, mk(pl(0), 3'd1, 4'd0));
    chk("bp_stable_valid", 72'(tx_valid), 72'd1);
    chk("bp_stable_count", 72'(count), 72'd4);
    tx_ready = 1'b1;
    tick();
    chk("bp_pop1_count", 72'(count), 72'd3);
    chk("bp_pop1_data", tx_data, mk(pl(1), 3'd1, 4'd1));
    chk("bp_pop1_ready", 72'(in_ready), 72'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_pushpop_count", 72'(count), 72'd3);
    chk("bp_data2", tx_data, mk(pl(2), 3'd1, 4'd2));
    tick();
    chk("bp_data3", tx_data, mk(pl(3), 3'd1, 4'd3));
    chk("bp_count2", 72'(count), 72'd2);
    tick();
    chk("bp_data4", tx_data, mk(pl(4), 3'd1, 4'd4));
    tick();
    chk("bp_drained", 72'(tx_valid), 72'd0);

    // seq wrap over 20 streamed payloads
    do_reset();
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = pl(100 + i); in_type = 3'd2;
      tick();
      chk($sformatf("wrap_flit_%0d", i), tx_data, mk(pl(100 + i), 3'd2, 4'(i % 16)));
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_drained", 72'(count), 72'd0);

    // type error
    do_reset();
    tx_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h0000_0000_0000_00FF; in_type = 3'd0;
    tick();
    in_valid = 1'b0;
    chk("terr_pulse", 72'(type_err), 72'd1);
    chk("terr_valid", 72'(tx_valid), 72'd1);
    chk("terr_data", tx_data, mk(64'h0000_0000_0000_00FF, 3'd0, 4'd0));
    tick();
    chk("terr_pulse_end", 72'(type_err), 72'd0);

    // reset mid-operation
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = pl(200 + i); in_type = 3'd4;
      tick();
    end
    in_valid = 1'b0;
    chk("mid_count3", 72'(count), 72'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_valid0", 72'(tx_valid), 72'd0);
    chk("mid_count0", 72'(count), 72'd0);
    chk("mid_ready", 72'(in_ready), 72'd1);
    tx_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h1234_5678_9ABC_DEF0; in_type = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("mid_seq0", tx_data, mk(64'h1234_5678_9ABC_DEF0, 3'd2, 4'd0));

    // idle insertion, IDLE_CYCLES=4
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0; tx_ready2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid2 = 1'b1; in_data2 = pl(300 + i); in_type2 = 3'd6;
      tick();
    end
    in_valid2 = 1'b0;
    chk("idle_last_data", tx_data2, mk(pl(302), 3'd6, 4'd2));
    tick();
    tx_ready2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("idle_wait_%0d", i), 72'(tx_valid2), 72'd0);
      tick();
    end
    // seq 3, type 0, payload 0: parity 0 -> bits [71:64] = 8'h18
    chk("idle_valid", 72'(tx_valid2), 72'd1);
    chk("idle_flit", tx_data2, 72'h18_0000_0000_0000_0000);
    in_valid2 = 1'b1; in_data2 = 64'hFACE_0000_0000_0001; in_type2 = 3'd5;
    tick();
    in_valid2 = 1'b0;
    chk("idle_hold1", tx_data2, 72'h18_0000_0000_0000_0000);
    chk("idle_hold_count", 72'(count2), 72'd1);
    tick();
    chk("idle_hold2", tx_data2, 72'h18_0000_0000_0000_0000);
    tx_ready2 = 1'b1;
    tick();
    chk("idle_after_data", tx_data2, mk(64'hFACE_0000_0000_0001, 3'd5, 4'd3));
    chk("idle_after_valid", 72'(tx_valid2), 72'd1);
    tick();
    chk("idle_drained", 72'(count2), 72'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
